// File: rtl/pong_gamepad_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : pong_gamepad_reader_if
//  Purpose  : Bundles the serial pad link (shared latch/clock, one data line
//             per pad) with the parallel button words and the frame strobe
//             handed to the pong game logic.
//  Revision : 1.0  initial release
// ============================================================================
interface pong_gamepad_reader_if #(
  parameter int NUM_BITS = 16
);
  // Pad-side serial link
  logic                pad_latch;
  logic                pad_clk;
  logic                pad_data_p1;
  logic                pad_data_p2;
  // Game-side parallel results
  logic [NUM_BITS-1:0] buttons_p1;
  logic [NUM_BITS-1:0] buttons_p2;
  logic                frame_valid;

  // The reader drives the pads and the game, and listens to the data lines
  modport master (
    output pad_latch,
    output pad_clk,
    input  pad_data_p1,
    input  pad_data_p2,
    output buttons_p1,
    output buttons_p2,
    output frame_valid
  );

  // Pads and game logic see the mirror image
  modport slave (
    input  pad_latch,
    input  pad_clk,
    output pad_data_p1,
    output pad_data_p2,
    input  buttons_p1,
    input  buttons_p2,
    input  frame_valid
  );
endinterface
`default_nettype wire

// File: rtl/pong_gamepad_reader.sv
`default_nettype none
// ============================================================================
//  Module   : pong_gamepad_reader
//  Purpose  : Polls two SNES-style serial gamepads on a fixed poll period and
//             presents active-high parallel button words plus a one-cycle
//             frame_valid strobe to the pong game logic.
//  Options  : GAMEPAD_DEBOUNCE_EN - when defined, a frame is only committed
//             if both players' raw words match the previous frame's words.
//  Revision : 1.0  initial release
// ============================================================================
module pong_gamepad_reader #(
  parameter int CLK_DIV     = 4,       // system cycles per pad_clk half-period (>=2)
  parameter int NUM_BITS    = 16,      // bits shifted per frame (>=3)
  parameter int POLL_PERIOD = 420000   // cycles between frame starts
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  pong_gamepad_reader_if.master bus
);

  localparam int c_POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int c_TMR_W  = $clog2(2 * CLK_DIV);
  localparam int c_BIT_W  = $clog2(NUM_BITS);

  localparam logic [c_POLL_W-1:0] c_POLL_LAST  = c_POLL_W'(POLL_PERIOD - 1);
  localparam logic [c_TMR_W-1:0]  c_LATCH_LAST = c_TMR_W'(2 * CLK_DIV - 1);
  localparam logic [c_TMR_W-1:0]  c_HALF_LAST  = c_TMR_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST   = c_BIT_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_sample;
  logic                w_commit;
  logic                w_accept;

  logic [c_POLL_W-1:0] r_poll_cnt;
  logic [c_TMR_W-1:0]  r_tmr;
  logic [c_BIT_W-1:0]  r_bit_cnt;

  logic [1:0]          r_sync_p1;
  logic [1:0]          r_sync_p2;
  logic                w_data_p1;
  logic                w_data_p2;

  // Only NUM_BITS-1 bits are stored: the final bit is taken straight from the
  // synchronizer at commit time, so the word is complete on the DONE edge.
  logic [NUM_BITS-2:0] r_shift_p1;
  logic [NUM_BITS-2:0] r_shift_p2;
  logic [NUM_BITS-1:0] w_raw_p1;
  logic [NUM_BITS-1:0] w_raw_p2;

  logic                r_pad_latch;
  logic                r_pad_clk;
  logic                r_frame_valid;
  logic [NUM_BITS-1:0] r_buttons_p1;
  logic [NUM_BITS-1:0] r_buttons_p2;

  assign w_data_p1 = r_sync_p1[1];
  assign w_data_p2 = r_sync_p2[1];

  // Pad lines are active-low; invert so a pressed button reads as 1
  assign w_raw_p1 = ~{w_data_p1, r_shift_p1};
  assign w_raw_p2 = ~{w_data_p2, r_shift_p2};

  // Two-flop synchronizers for the asynchronous pad data lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p1 <= 2'b11;
      r_sync_p2 <= 2'b11;
    end else begin
      r_sync_p1 <= {r_sync_p1[0], bus.pad_data_p1};
      r_sync_p2 <= {r_sync_p2[0], bus.pad_data_p2};
    end
  end

  // Free-running poll counter; sets the frame cadence independent of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
    end else if (r_poll_cnt == c_POLL_LAST) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the sample/commit strobes tied to phase ends
  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_poll_cnt == '0) && en) begin
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (r_tmr == c_LATCH_LAST) begin
          w_sample    = 1'b1;
          w_state_nxt = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (r_tmr == c_HALF_LAST) begin
          w_state_nxt = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (r_tmr == c_HALF_LAST) begin
          w_sample = 1'b1;
          if (r_bit_cnt == c_BIT_LAST) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT_LO;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Phase timer restarts on every state change and is held at zero in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  // Counts bits captured so far; back to zero once the frame commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (w_commit) begin
      r_bit_cnt <= '0;
    end else if (w_sample) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Shift registers fill from the top so the first bit lands in bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_p1 <= '0;
      r_shift_p2 <= '0;
    end else if (w_sample) begin
      r_shift_p1 <= {w_data_p1, r_shift_p1[NUM_BITS-2:1]};
      r_shift_p2 <= {w_data_p2, r_shift_p2[NUM_BITS-2:1]};
    end
  end

`ifdef GAMEPAD_DEBOUNCE_EN
  logic [NUM_BITS-1:0] r_prev_p1;
  logic [NUM_BITS-1:0] r_prev_p2;

  // Remember every frame's raw words so the next frame can be compared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_p1 <= '0;
      r_prev_p2 <= '0;
    end else if (w_commit) begin
      r_prev_p1 <= w_raw_p1;
      r_prev_p2 <= w_raw_p2;
    end
  end

  assign w_accept = (w_raw_p1 == r_prev_p1) && (w_raw_p2 == r_prev_p2);
`else
  assign w_accept = 1'b1;
`endif

  // Pad strobes are registered copies of the next-state decode so they
  // change only on clock edges and line up exactly with the FSM phases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b1;
    end else begin
      r_pad_latch <= (w_state_nxt == ST_LATCH);
      r_pad_clk   <= (w_state_nxt != ST_SHIFT_LO);
    end
  end

  // Commit on entry to DONE so frame_valid and the new words appear in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_buttons_p1  <= '0;
      r_buttons_p2  <= '0;
    end else begin
      r_frame_valid <= w_commit && w_accept;
      if (w_commit && w_accept) begin
        r_buttons_p1 <= w_raw_p1;
        r_buttons_p2 <= w_raw_p2;
      end
    end
  end

  assign bus.pad_latch   = r_pad_latch;
  assign bus.pad_clk     = r_pad_clk;
  assign bus.frame_valid = r_frame_valid;
  assign bus.buttons_p1  = r_buttons_p1;
  assign bus.buttons_p2  = r_buttons_p2;

endmodule
`default_nettype wire
